alu_cmd_feeder: RTL and testbench
=================================

Name: alu_cmd_feeder

Overview:
- Upstream issue stage for the 4-bit signed ALU (alu4bit).
- Accepts operand/opcode commands over a valid/ready interface and buffers them in a small FIFO.
- Drives the ALU's A/B/opcode inputs one command at a time and waits out the ALU's registered latency.
- Captures C and presents it, tagged with its opcode, on a valid/ready result port.

Parameters:
- DEPTH, 4, command FIFO entries (power of 2, >=2).
- ALU_LATENCY, 1, posedges from ALU inputs changing to C holding the corresponding result (>=1).

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  command offered.
- in_ready  out  1  FIFO can accept; equals !full.
- in_a  in  4  signed operand A.
- in_b  in  4  signed operand B.
- in_op  in  2  opcode: 00 add, 01 sub, 10 invert A, 11 reduction-OR of B.
- alu_a  out  4  to ALU A, registered.
- alu_b  out  4  to ALU B, registered.
- alu_op  out  2  to ALU opcode, registered.
- alu_c  in  5  signed result from ALU C.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_c  out  5  captured signed result.
- res_op  out  2  opcode of the captured result.
- fifo_count  out  clog2(DEPTH)+1  entries currently buffered.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release):
  - FIFO empty; fifo_count=0; in_ready=1.
  - alu_a/alu_b/alu_op=0; res_valid=0; res_c=0; res_op=0.
  - state=IDLE; any in-flight command is discarded.
- Push: when in_valid && in_ready, write {in_a,in_b,in_op} at the tail.
  - When full, in_ready=0 and input is held off; there is no full-bypass.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
  - IDLE: if FIFO non-empty, pop the head, load alu_a/b/op, go to ISSUE. Otherwise stay.
  - ISSUE: load wait counter with ALU_LATENCY-1, go to WAIT. ALU samples its inputs at this edge.
  - WAIT: while counter != 0, decrement. When counter == 0, set res_c<=alu_c, res_op<=alu_op, res_valid<=1, go to HOLD.
  - HOLD: if res_ready, clear res_valid. Then, if FIFO non-empty, pop the head and go to ISSUE directly; otherwise go to IDLE. If !res_ready, hold res_c/res_op/res_valid stable.
- alu_a/b/op stay stable from issue until the next pop; they are never changed mid-operation.
- Timing with ALU_LATENCY=1, empty pipe:
  - Command pushed at edge t0 is popped at t1.
  - ALU computes at t2.
  - res_valid rises at t3.
- Back-to-back throughput: one result per 3 cycles when res_ready is held high.
- Simultaneous push and pop in the same cycle:
  - fifo_count is unchanged.
  - A push into an empty FIFO is not popped in the same cycle; the command must be visible in the FIFO first.
- FIFO pointers wrap modulo DEPTH; fifo_count saturates by construction at DEPTH, never DEPTH+1.
- Reset asserted in any state returns immediately to the reset values.

Optional Feature:
- Macro: ALU_REF_CHECK_EN.
- When defined, an internal reference model computes the expected 5-bit signed result from the issued operands:
  - add: sext(A)+sext(B).
  - sub: sext(A)-sext(B).
  - invert: sext(~A).
  - reduction-OR: {4'b0, |B}.
- The expected value is compared with alu_c at the capture edge.
- Extra outputs: chk_err (1, sticky, cleared only by rst) and chk_err_cnt (8, saturating at 255).
- When undefined, those ports and all checker logic are absent.

Test Plan:
- Reset then push (4,3,00) -> res_valid rises 3 cycles after the push; res_c=7, res_op=00.
- Push (-4,2,00), (5,1,01), (-3,-4,01) back-to-back with res_ready=1 -> results -2, 4, 1 in order, one every 3 cycles; fifo_count peaks at 2.
- Push (4,0,10), (-2,0,10), (10,1010,11), (0,0000,11) -> results -5, 1, 1, 0.
- Hold res_ready=0 and push DEPTH+2 commands:
  - in_ready drops once fifo_count reaches 4.
  - res_c stays stable.
  - Releasing res_ready drains every result in order with no loss or duplication.
- Assert rst during WAIT with 2 commands queued -> all outputs at reset values within the same cycle; no stale result appears after release.
- With ALU_REF_CHECK_EN defined, force alu_c=0 for an add of (4,3) -> chk_err=1 and chk_err_cnt=1, both persisting until rst.

Source files
------------

// File: rtl/alu_cmd_feeder.sv
// Issue stage for the 4-bit ALU: buffers commands, issues one at a time, captures and presents results.
// Optional reference checker on the ALU result is enabled by defining ALU_REF_CHECK_EN.
module alu_cmd_feeder #(
  parameter int DEPTH       = 4,
  parameter int ALU_LATENCY = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [3:0]               in_a,
  input  logic [3:0]               in_b,
  input  logic [1:0]               in_op,
  output logic [3:0]               alu_a,
  output logic [3:0]               alu_b,
  output logic [1:0]               alu_op,
  input  logic [4:0]               alu_c,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [4:0]               res_c,
  output logic [1:0]               res_op,
  output logic [$clog2(DEPTH):0]   fifo_count,
`ifdef ALU_REF_CHECK_EN
  output logic                     chk_err,
  output logic [7:0]               chk_err_cnt,
`endif
  output logic                     busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [CW-1:0] WAIT_INIT = CW'(ALU_LATENCY - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_HOLD} state_t;

  logic [9:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_wait_cnt;
  logic [3:0]    r_alu_a, r_alu_b;
  logic [1:0]    r_alu_op;
  logic          r_res_valid;
  logic [4:0]    r_res_c;
  logic [1:0]    r_res_op;

  logic          w_full, w_empty, w_push, w_pop, w_capture, w_release;
  logic [9:0]    w_head;

  assign w_full  = (r_count == (AW+1)'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_push  = in_valid && !w_full;
  assign w_head  = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {in_a, in_b, in_op};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Pops look only at the registered count, so a command is never popped in its push cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_capture   = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_capture   = 1'b1;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (res_ready) begin
          w_release = 1'b1;
          if (!w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_ISSUE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_wait_cnt  <= '0;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= '0;
      r_res_valid <= 1'b0;
      r_res_c     <= '0;
      r_res_op    <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_ISSUE)
        r_wait_cnt <= WAIT_INIT;
      else if (r_state == S_WAIT && r_wait_cnt != '0)
        r_wait_cnt <= r_wait_cnt - CW'(1);
      if (w_pop) begin
        r_alu_a  <= w_head[9:6];
        r_alu_b  <= w_head[5:2];
        r_alu_op <= w_head[1:0];
      end
      if (w_capture) begin
        r_res_c     <= alu_c;
        r_res_op    <= r_alu_op;
        r_res_valid <= 1'b1;
      end else if (w_release) begin
        r_res_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_REF_CHECK_EN
  logic [4:0] w_exp;
  logic       r_chk_err;
  logic [7:0] r_chk_err_cnt;

  always_comb begin
    w_exp = '0;
    case (r_alu_op)
      2'b00:   w_exp = {r_alu_a[3], r_alu_a} + {r_alu_b[3], r_alu_b};
      2'b01:   w_exp = {r_alu_a[3], r_alu_a} - {r_alu_b[3], r_alu_b};
      2'b10:   w_exp = ~{r_alu_a[3], r_alu_a};
      default: w_exp = {4'b0000, |r_alu_b};
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk_err     <= 1'b0;
      r_chk_err_cnt <= '0;
    end else if (w_capture && (alu_c != w_exp)) begin
      r_chk_err <= 1'b1;
      if (r_chk_err_cnt != 8'hFF) r_chk_err_cnt <= r_chk_err_cnt + 8'd1;
    end
  end

  assign chk_err     = r_chk_err;
  assign chk_err_cnt = r_chk_err_cnt;
`endif

  assign in_ready   = !w_full;
  assign alu_a      = r_alu_a;
  assign alu_b      = r_alu_b;
  assign alu_op     = r_alu_op;
  assign res_valid  = r_res_valid;
  assign res_c      = r_res_c;
  assign res_op     = r_res_op;
  assign fifo_count = r_count;
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_cmd_feeder.sv
// Randomized bench for alu_cmd_feeder with a queue-based scoreboard and a behavioural ALU.
module tb_alu_cmd_feeder;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_a = '0, in_b = '0;
  logic [1:0] in_op = '0;
  logic [3:0] alu_a, alu_b;
  logic [1:0] alu_op;
  logic [4:0] alu_c = '0;
  logic       res_valid;
  logic       res_ready = 1'b1;
  logic [4:0] res_c;
  logic [1:0] res_op;
  logic [2:0] fifo_count;
  logic       busy;
`ifdef ALU_REF_CHECK_EN
  logic       chk_err;
  logic [7:0] chk_err_cnt;
`endif

  alu_cmd_feeder #(.DEPTH(DEPTH), .ALU_LATENCY(1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_c(alu_c),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_c(res_c), .res_op(res_op),
    .fifo_count(fifo_count),
`ifdef ALU_REF_CHECK_EN
    .chk_err(chk_err), .chk_err_cnt(chk_err_cnt),
`endif
    .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc++;

  // Signed integer semantics of the ALU; every result fits 5-bit signed range.
  function automatic int ref_alu(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'd0:    return sa + sb;
      2'd1:    return sa - sb;
      2'd2:    return -sa - 1;
      default: return (b != 0) ? 1 : 0;
    endcase
  endfunction

  logic force_zero = 1'b0;
  always @(posedge clk) alu_c <= force_zero ? 5'd0 : 5'(ref_alu(alu_a, alu_b, alu_op));

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct { int c; int op; } exp_t;
  exp_t sbq[$];
  int   got_c[$];
  int   hs_cyc[$];
  int   peak = 0;
  logic prev_hold = 1'b0;
  logic [4:0] prev_c;
  logic [1:0] prev_op;

  always @(negedge clk) begin
    if (rst) begin
      sbq.delete();
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        check("hold_valid", res_valid, 1);
        check("hold_c", res_c, prev_c);
        check("hold_op", res_op, prev_op);
      end
      check("in_ready_vs_full", in_ready, (fifo_count < DEPTH) ? 1 : 0);
      check("occupancy", ((sbq.size() - fifo_count) inside {0, 1}) ? 1 : 0, 1);
      check("busy", busy, (sbq.size() != fifo_count) ? 1 : 0);
      if (fifo_count > peak) peak = fifo_count;
      if (res_valid && res_ready) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_result: got c=%0d with no command outstanding", $signed(res_c));
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check("res_c", $signed(res_c), e.c);
          check("res_op", res_op, e.op);
          got_c.push_back($signed(res_c));
          hs_cyc.push_back(cyc);
        end
      end
      prev_hold = res_valid && !res_ready;
      prev_c    = res_c;
      prev_op   = res_op;
      if (in_valid && in_ready)
        sbq.push_back('{force_zero ? 0 : ref_alu(in_a, in_b, in_op), int'(in_op)});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    bit ok;
    ok = 0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_op = op;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1; break; end
    end
    if (!ok) check("push_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n_target);
    bit ok;
    ok = 0;
    for (int k = 0; k < 300; k++) begin
      if (got_c.size() >= n_target) begin ok = 1; break; end
      tick(1);
    end
    if (!ok) check("result_timeout", got_c.size(), n_target);
  endtask

  initial begin
    int n0, lat;
    #2 rst = 1'b1;
    tick(2);
    check("rst_in_ready", in_ready, 1);
    check("rst_count", fifo_count, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_alu", {alu_a, alu_b, alu_op}, 0);
    check("rst_res", {res_c, res_op}, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    tick(2);

    check("model_add", ref_alu(4'd4, 4'd3, 2'd0), 7);
    check("model_sub", ref_alu(4'b1101, 4'b1100, 2'd1), 1);
    check("model_inv", ref_alu(4'd4, 4'd0, 2'd2), -5);
    check("model_or", ref_alu(4'd10, 4'b1010, 2'd3), 1);

    // Single command latency
    push(4'd4, 4'd3, 2'd0);
    lat = 0;
    for (int k = 1; k <= 10; k++) begin
      tick(1);
      if (res_valid) begin lat = k; break; end
    end
    check("latency", lat, 3);
    check("first_c", $signed(res_c), 7);
    check("first_op", res_op, 0);
    tick(4);

    // Back-to-back throughput
    peak = 0;
    n0 = got_c.size();
    push(4'b1100, 4'd2, 2'd0);
    push(4'd5, 4'd1, 2'd1);
    push(4'b1101, 4'b1100, 2'd1);
    wait_results(n0 + 3);
    if (got_c.size() >= n0 + 3) begin
      check("b2b_r0", got_c[n0], -2);
      check("b2b_r1", got_c[n0+1], 4);
      check("b2b_r2", got_c[n0+2], 1);
      check("b2b_gap0", hs_cyc[n0+1] - hs_cyc[n0], 3);
      check("b2b_gap1", hs_cyc[n0+2] - hs_cyc[n0+1], 3);
    end
    check("b2b_peak", peak, 2);
    tick(3);

    // Invert and reduction-OR
    n0 = got_c.size();
    push(4'd4, 4'd0, 2'd2);
    push(4'b1110, 4'd0, 2'd2);
    push(4'd10, 4'b1010, 2'd3);
    push(4'd0, 4'b0000, 2'd3);
    wait_results(n0 + 4);
    if (got_c.size() >= n0 + 4) begin
      check("inv_r0", got_c[n0], -5);
      check("inv_r1", got_c[n0+1], 1);
      check("or_r2", got_c[n0+2], 1);
      check("or_r3", got_c[n0+3], 0);
    end
    tick(3);

    // Backpressure: fill the FIFO behind a stalled result
    res_ready = 1'b0;
    n0 = got_c.size();
    push(4'd1, 4'd1, 2'd0);
    push(4'd2, 4'd3, 2'd1);
    push(4'd3, 4'd3, 2'd0);
    push(4'b1111, 4'b1111, 2'd0);
    push(4'b1000, 4'b1000, 2'd1);
    in_valid = 1'b1; in_a = 4'd7; in_b = 4'd7; in_op = 2'd0;
    tick(5);
    check("full_in_ready", in_ready, 0);
    check("full_count", fifo_count, 4);
    check("full_res_valid", res_valid, 1);
    check("full_res_c", $signed(res_c), 2);
    res_ready = 1'b1;
    begin
      bit ok;
      ok = 0;
      for (int k = 0; k < 50; k++) begin
        @(negedge clk);
        if (in_ready) begin ok = 1; break; end
      end
      if (!ok) check("full_push_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
    end
    wait_results(n0 + 6);
    tick(3);
    check("drain_count", got_c.size() - n0, 6);
    check("drain_sbq", sbq.size(), 0);
    if (got_c.size() >= n0 + 6) check("drain_last", got_c[n0+5], 14);

    // Reset while waiting on the ALU with two commands queued
    push(4'd1, 4'd2, 2'd0);
    push(4'd3, 4'd4, 2'd0);
    push(4'd5, 4'd6, 2'd0);
    check("pre_rst_busy", busy, 1);
    check("pre_rst_count", fifo_count, 2);
    rst = 1'b1;
    #1;
    check("mid_rst_count", fifo_count, 0);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_alu", {alu_a, alu_b, alu_op}, 0);
    check("mid_rst_res", {res_c, res_op}, 0);
    tick(2);
    rst = 1'b0;
    n0 = got_c.size();
    tick(12);
    check("post_rst_results", got_c.size() - n0, 0);
    check("post_rst_count", fifo_count, 0);

`ifdef ALU_REF_CHECK_EN
    force_zero = 1'b1;
    push(4'd4, 4'd3, 2'd0);
    tick(6);
    force_zero = 1'b0;
    check("chk_err", chk_err, 1);
    check("chk_err_cnt", chk_err_cnt, 1);
    tick(5);
    check("chk_err_sticky", chk_err, 1);
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    check("chk_err_clr", chk_err, 0);
    check("chk_err_cnt_clr", chk_err_cnt, 0);
    tick(2);
`endif

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 2) != 0);
      in_a      = 4'($urandom);
      in_b      = 4'($urandom);
      in_op     = 2'($urandom);
      res_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    in_valid  = 1'b0;
    res_ready = 1'b1;
    begin
      bit ok;
      ok = 0;
      for (int k = 0; k < 300; k++) begin
        tick(1);
        if (sbq.size() == 0 && !busy && fifo_count == 0) begin ok = 1; break; end
      end
      check("random_drain", ok, 1);
    end
    tick(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
